unary_shift_mac: RTL and testbench
==================================

UNARY_SHIFT_MAC -- requirements
Module: unary_shift_mac

Interface
REQ-001 SHALL have parameter BIN_BITS, default 4: binary operand width; unary operand length U = 2^BIN_BITS.
REQ-002 SHALL have parameter LAST_EN, default 1: when 1, honour in_last/out_last; when 0, tie out_last low and ignore in_last.
REQ-003 clk  input  1  system clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_a  input  1  operand A, serial unary (value = count of 1s in accepted beats of a frame).
REQ-006 in_b  input  1  operand B, serial unary, same beats as in_a.
REQ-007 in_valid  input  1  qualifies in_a/in_b/in_last; frame = maximal run of accepted beats.
REQ-008 in_last  input  1  marks current frame as final term of a dot product.
REQ-009 in_ready  output  1  block can accept a beat.
REQ-010 out  output  1  product/accumulation stream, serial unary.
REQ-011 out_valid  output  1  qualifies out and out_last.
REQ-012 out_ready  input  1  consumer backpressure.
REQ-013 out_last  output  1  final beat of a dot product.
REQ-014 overflow  output  1  sticky: a frame exceeded U beats.

Function
REQ-015 Beat accepted iff in_valid && in_ready; output beat transferred iff out_valid && out_ready.
REQ-016 States IDLE, LOAD, EMIT; in_ready = 1 in IDLE/LOAD, 0 in EMIT.
REQ-017 IDLE -> LOAD on first accepted beat; that beat is loaded.
REQ-018 LOAD: each accepted beat adds in_a to A and in_b to B; in_last is OR-ed into a per-frame last flag.
REQ-019 LOAD ends on first cycle with in_valid low; next state EMIT if A*B > 0 or last flag set, else IDLE.
REQ-020 Frame beats beyond U: accepted, operand bits discarded, overflow set; A and B saturate at U.
REQ-021 EMIT: exactly A*B beats with out=1, out_valid=1, one per cycle while out_ready high; stalls, holding out/out_valid/out_last, while out_ready low.
REQ-022 First EMIT beat is presented the cycle after the ending in_valid-low cycle (latency 1).
REQ-023 out_last = 1 only on the final EMIT beat of a frame whose last flag is set.
REQ-024 Zero product with last flag set: single beat out=0, out_valid=1, out_last=1.
REQ-025 EMIT -> IDLE on transfer of the final beat; A, B, last flag cleared.
REQ-026 out_valid = 0 and out = 0 in IDLE and LOAD.
REQ-027 Successive frames form one unary accumulation: sum of emitted 1s between out_last beats = dot product.
REQ-028 in_valid asserted during EMIT is not accepted; the producer holds it.

Reset
REQ-029 reset_n low asynchronously forces IDLE, clears A, B, last flag and overflow; abandons any frame or emission in progress.
REQ-030 During and after reset, until the first accepted beat: in_ready=1, out=0, out_valid=0, out_last=0, overflow=0.

Structure
REQ-031 Package unary_pkg SHALL hold the state enum and a U_BITS(BIN_BITS) constant function.
REQ-032 Sub-module unary_frame_loader SHALL hold the A/B thermometer registers, saturation and overflow detection; the FSM and emit counters stay in unary_shift_mac.

Verification (BIN_BITS=2, U=4)
REQ-033 Frame a=1110, b=1100, in_last=1, out_ready=1 -> 6 beats out=1 from cycle after frame end, out_last on 6th, in_ready low throughout.
REQ-034 Frames (a=2,b=1) then (a=1,b=3, in_last) -> 2 beats, no out_last; then 3 beats, out_last on 3rd; total 5 ones.
REQ-035 Frame a=0, b=3, in_last=1 -> one beat out=0, out_valid=1, out_last=1; a=0, b=3, in_last=0 -> no beats, back to IDLE.
REQ-036 a=3, b=3, out_ready toggling 1,0,1,0 -> 9 transfers, out stable across stalls, out_last on 9th transfer only.
REQ-037 6-beat frame, all ones -> overflow=1, A=B=4, 16 beats emitted.
REQ-038 reset_n pulsed low at 4th EMIT beat -> outputs zero immediately, in_ready=1, next frame processed normally.

Source files
------------

// File: rtl/unary_pkg.sv
// rtl/unary_pkg.sv - shared types and sizing helpers for the unary shift MAC
package unary_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  // Bits needed to hold a unary count in 0..2^bin_bits inclusive.
  function automatic int U_BITS(input int bin_bits);
    return bin_bits + 1;
  endfunction

endpackage

// File: rtl/unary_shift_mac_if.sv
// rtl/unary_shift_mac_if.sv - serial unary operand/product handshake bundle
interface unary_shift_mac_if;

  logic in_a;
  logic in_b;
  logic in_valid;
  logic in_last;
  logic in_ready;
  logic out;
  logic out_valid;
  logic out_ready;
  logic out_last;
  logic overflow;

  modport master (
    output in_a, in_b, in_valid, in_last, out_ready,
    input  in_ready, out, out_valid, out_last, overflow
  );

  modport slave (
    input  in_a, in_b, in_valid, in_last, out_ready,
    output in_ready, out, out_valid, out_last, overflow
  );

endinterface

// File: rtl/unary_frame_loader.sv
// rtl/unary_frame_loader.sv - thermometer accumulation of one unary frame with saturation
module unary_frame_loader
  import unary_pkg::*;
#(
  parameter int BIN_BITS = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        load_i,
  input  logic                        clear_i,
  input  logic                        a_i,
  input  logic                        b_i,
  input  logic                        last_i,
  output logic [U_BITS(BIN_BITS)-1:0] a_cnt_o,
  output logic [U_BITS(BIN_BITS)-1:0] b_cnt_o,
  output logic                        last_o,
  output logic                        overflow_o
);

  localparam int U  = 1 << BIN_BITS;
  localparam int CW = U_BITS(BIN_BITS);

  logic [U-1:0]  a_therm_q;
  logic [U-1:0]  b_therm_q;
  logic [CW-1:0] beats_q;
  logic          last_q;
  logic          ovf_q;
  logic          full;

  // Once U beats are in, further beats only flag overflow; their operand bits are dropped.
  assign full = (beats_q == CW'(U));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_therm_q <= '0;
      b_therm_q <= '0;
      beats_q   <= '0;
      last_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (clear_i) begin
      a_therm_q <= '0;
      b_therm_q <= '0;
      beats_q   <= '0;
      last_q    <= 1'b0;
    end else if (load_i) begin
      last_q <= last_q | last_i;
      if (full) begin
        ovf_q <= 1'b1;
      end else begin
        beats_q <= beats_q + CW'(1);
        if (a_i) a_therm_q <= {a_therm_q[U-2:0], 1'b1};
        if (b_i) b_therm_q <= {b_therm_q[U-2:0], 1'b1};
      end
    end
  end

  always_comb begin
    a_cnt_o = '0;
    b_cnt_o = '0;
    for (int i = 0; i < U; i++) begin
      a_cnt_o = a_cnt_o + CW'(a_therm_q[i]);
      b_cnt_o = b_cnt_o + CW'(b_therm_q[i]);
    end
  end

  assign last_o     = last_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/unary_shift_mac.sv
// rtl/unary_shift_mac.sv - serial unary multiply-accumulate: loads A/B frames, emits A*B ones
module unary_shift_mac
  import unary_pkg::*;
#(
  parameter int BIN_BITS = 4,
  parameter int LAST_EN  = 1
) (
  input logic               clk,
  input logic               reset_n,
  unary_shift_mac_if.slave  bus
);

  localparam int CW = U_BITS(BIN_BITS);
  localparam int PW = 2 * CW;

  state_e        state_q, state_d;
  logic [PW-1:0] rem_q, rem_d;
  logic          zero_q, zero_d;
  logic          last_q, last_d;

  logic          accept;
  logic          xfer;
  logic          load_clear;
  logic [CW-1:0] a_cnt;
  logic [CW-1:0] b_cnt;
  logic          frame_last;
  logic          frame_last_eff;
  logic          frame_ovf;
  logic [PW-1:0] prod;
  logic          final_beat;

  assign accept         = bus.in_valid && bus.in_ready;
  assign xfer           = bus.out_valid && bus.out_ready;
  assign frame_last_eff = (LAST_EN != 0) && frame_last;
  assign prod           = PW'(a_cnt) * PW'(b_cnt);

  unary_frame_loader #(
    .BIN_BITS (BIN_BITS)
  ) u_loader (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (accept),
    .clear_i    (load_clear),
    .a_i        (bus.in_a),
    .b_i        (bus.in_b),
    .last_i     ((LAST_EN != 0) && bus.in_last),
    .a_cnt_o    (a_cnt),
    .b_cnt_o    (b_cnt),
    .last_o     (frame_last),
    .overflow_o (frame_ovf)
  );

  // The product and last flag are latched at frame end, so the loader is freed right away.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    zero_d     = zero_q;
    last_d     = last_q;
    load_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (!bus.in_valid) begin
          load_clear = 1'b1;
          if ((prod != '0) || frame_last_eff) begin
            state_d = ST_EMIT;
            rem_d   = prod;
            zero_d  = (prod == '0);
            last_d  = frame_last_eff;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_EMIT: begin
        if (xfer) begin
          if (final_beat) begin
            state_d = ST_IDLE;
            rem_d   = '0;
            zero_d  = 1'b0;
            last_d  = 1'b0;
          end else begin
            rem_d = rem_q - PW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      zero_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      zero_q  <= zero_d;
      last_q  <= last_d;
    end
  end

  // A zero product with the last flag still needs one marker beat carrying out_last.
  assign final_beat    = zero_q || (rem_q == PW'(1));
  assign bus.in_ready  = (state_q != ST_EMIT);
  assign bus.out_valid = (state_q == ST_EMIT);
  assign bus.out       = (state_q == ST_EMIT) && !zero_q;
  assign bus.out_last  = (LAST_EN != 0) && (state_q == ST_EMIT) && last_q && final_beat;
  assign bus.overflow  = frame_ovf;

endmodule

// File: tb/tb_unary_shift_mac.sv
// tb/tb_unary_shift_mac.sv - randomized self-checking bench for unary_shift_mac (BIN_BITS=2)
module tb_unary_shift_mac;

  localparam int BB = 2;
  localparam int U  = 1 << BB;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;
  bit   ovf_m;

  unary_shift_mac_if bus ();

  unary_shift_mac #(
    .BIN_BITS (BB),
    .LAST_EN  (1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: operand value = ones among the first U beats of the frame.
  function automatic int m_count(input logic [7:0] v, input int n);
    int c;
    c = 0;
    for (int i = 0; i < n && i < U; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic int m_beats(input int p, input bit last);
    if (p > 0) return p;
    return last ? 1 : 0;
  endfunction

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input int n,
                            input bit last, output bit rdy_ok);
    rdy_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = a[i];
      bus.in_b     = b[i];
      bus.in_last  = last && (i == n - 1);
      #1;
      if (bus.in_ready !== 1'b1) rdy_ok = 1'b0;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_a     = 1'b0;
    bus.in_b     = 1'b0;
    bus.in_last  = 1'b0;
    if (n > U) ovf_m = 1'b1;
  endtask

  task automatic run_emit(input bit toggle, output int ones, output int xfers,
                          output int last_pos, output int lasts, output bit first_valid,
                          output bit stable_ok, output bit ready_ok, output bit timeout);
    bit   prev_stall;
    logic prev_out, prev_last;
    bit   done;
    ones = 0; xfers = 0; last_pos = 0; lasts = 0; first_valid = 1'b0;
    stable_ok = 1'b1; ready_ok = 1'b1; done = 1'b0;
    prev_stall = 1'b0; prev_out = 1'b0; prev_last = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      bus.out_ready = toggle ? ~cyc[0] : 1'b1;
      #1;
      if (cyc == 0) first_valid = bus.out_valid;
      if (bus.out_valid !== 1'b1) begin
        done = 1'b1;
        break;
      end
      if (bus.in_ready !== 1'b0) ready_ok = 1'b0;
      if (prev_stall && (bus.out !== prev_out || bus.out_last !== prev_last)) stable_ok = 1'b0;
      prev_stall = !bus.out_ready;
      prev_out   = bus.out;
      prev_last  = bus.out_last;
      if (bus.out_ready) begin
        xfers++;
        ones += int'(bus.out);
        if (bus.out_last) begin
          lasts++;
          last_pos = xfers;
        end
      end
    end
    bus.out_ready = 1'b1;
    timeout = !done;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    bus.in_a = 1'b0; bus.in_b = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    ovf_m = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.out, bus.out_valid, bus.out_last, bus.overflow} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_during: got %b want 10000",
               {bus.in_ready, bus.out, bus.out_valid, bus.out_last, bus.overflow});
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.out, bus.out_valid, bus.out_last, bus.overflow} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_after: got %b want 10000",
               {bus.in_ready, bus.out, bus.out_valid, bus.out_last, bus.overflow});
    end
  endtask

  task automatic test_single;
    int ones, xfers, lpos, lasts, p;
    bit fv, st, rd, to, rk;
    p = m_count(8'b0111, 4) * m_count(8'b0011, 4);
    send_frame(8'b0111, 8'b0011, 4, 1'b1, rk);
    run_emit(1'b0, ones, xfers, lpos, lasts, fv, st, rd, to);
    checks++;
    if (!fv || to) begin
      errors++;
      $display("FAIL single_latency: first_valid=%0d timeout=%0d want 1/0", fv, to);
    end
    checks++;
    if (ones !== p || xfers !== p) begin
      errors++;
      $display("FAIL single_count: ones=%0d xfers=%0d want %0d", ones, xfers, p);
    end
    checks++;
    if (lasts !== 1 || lpos !== p) begin
      errors++;
      $display("FAIL single_last: lasts=%0d pos=%0d want 1 at %0d", lasts, lpos, p);
    end
    checks++;
    if (!rd || !rk) begin
      errors++;
      $display("FAIL single_in_ready: emit_low=%0d load_high=%0d want 1/1", rd, rk);
    end
  endtask

  task automatic test_accum;
    int ones, xfers, lpos, lasts, p1, p2, total;
    bit fv, st, rd, to, rk;
    p1 = m_count(8'b011, 3) * m_count(8'b100, 3);
    p2 = m_count(8'b001, 3) * m_count(8'b111, 3);
    send_frame(8'b011, 8'b100, 3, 1'b0, rk);
    run_emit(1'b0, ones, xfers, lpos, lasts, fv, st, rd, to);
    total = ones;
    checks++;
    if (xfers !== p1 || lasts !== 0) begin
      errors++;
      $display("FAIL accum_frame1: xfers=%0d lasts=%0d want %0d/0", xfers, lasts, p1);
    end
    send_frame(8'b001, 8'b111, 3, 1'b1, rk);
    run_emit(1'b0, ones, xfers, lpos, lasts, fv, st, rd, to);
    total += ones;
    checks++;
    if (xfers !== p2 || lasts !== 1 || lpos !== p2) begin
      errors++;
      $display("FAIL accum_frame2: xfers=%0d lasts=%0d pos=%0d want %0d/1/%0d",
               xfers, lasts, lpos, p2, p2);
    end
    checks++;
    if (total !== p1 + p2) begin
      errors++;
      $display("FAIL accum_total: got %0d want %0d", total, p1 + p2);
    end
  endtask

  task automatic test_zero;
    int ones, xfers, lpos, lasts;
    bit fv, st, rd, to, rk;
    send_frame(8'b000, 8'b111, 3, 1'b1, rk);
    run_emit(1'b0, ones, xfers, lpos, lasts, fv, st, rd, to);
    checks++;
    if (!fv || xfers !== 1 || ones !== 0 || lasts !== 1) begin
      errors++;
      $display("FAIL zero_last: valid=%0d xfers=%0d ones=%0d lasts=%0d want 1/1/0/1",
               fv, xfers, ones, lasts);
    end
    send_frame(8'b000, 8'b111, 3, 1'b0, rk);
    run_emit(1'b0, ones, xfers, lpos, lasts, fv, st, rd, to);
    checks++;
    if (fv || xfers !== 0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_nolast: valid=%0d xfers=%0d in_ready=%b want 0/0/1",
               fv, xfers, bus.in_ready);
    end
  endtask

  task automatic test_backpressure;
    int ones, xfers, lpos, lasts, p;
    bit fv, st, rd, to, rk;
    p = m_count(8'b0111, 3) * m_count(8'b0111, 3);
    send_frame(8'b0111, 8'b0111, 3, 1'b1, rk);
    run_emit(1'b1, ones, xfers, lpos, lasts, fv, st, rd, to);
    checks++;
    if (xfers !== p || ones !== p || to) begin
      errors++;
      $display("FAIL bp_count: xfers=%0d ones=%0d want %0d", xfers, ones, p);
    end
    checks++;
    if (!st) begin
      errors++;
      $display("FAIL bp_stable: outputs changed during stall, got 0 want 1");
    end
    checks++;
    if (lasts !== 1 || lpos !== p) begin
      errors++;
      $display("FAIL bp_last: lasts=%0d pos=%0d want 1 at %0d", lasts, lpos, p);
    end
  endtask

  task automatic test_overflow;
    int ones, xfers, lpos, lasts, p;
    bit fv, st, rd, to, rk;
    p = m_count(8'h3f, 6) * m_count(8'h3f, 6);
    send_frame(8'h3f, 8'h3f, 6, 1'b1, rk);
    run_emit(1'b0, ones, xfers, lpos, lasts, fv, st, rd, to);
    checks++;
    if (ones !== p || lpos !== p) begin
      errors++;
      $display("FAIL ovf_saturate: ones=%0d last_pos=%0d want %0d", ones, lpos, p);
    end
    checks++;
    if (bus.overflow !== ovf_m) begin
      errors++;
      $display("FAIL ovf_flag: got %b want %b", bus.overflow, ovf_m);
    end
  endtask

  task automatic test_reset_mid_emit;
    int ones, xfers, lpos, lasts, n, p;
    bit fv, st, rd, to, rk;
    send_frame(8'b0111, 8'b0111, 3, 1'b1, rk);
    n = 0;
    for (int cyc = 0; cyc < 50 && n < 3; cyc++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid === 1'b1) n++;
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || n !== 3) begin
      errors++;
      $display("FAIL rstmid_pre: out_valid=%b seen=%0d want 1/3", bus.out_valid, n);
    end
    reset_n = 1'b0;
    ovf_m = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out, bus.out_valid, bus.out_last, bus.overflow} !== 5'b10000) begin
      errors++;
      $display("FAIL rstmid_async: got %b want 10000",
               {bus.in_ready, bus.out, bus.out_valid, bus.out_last, bus.overflow});
    end
    @(negedge clk);
    reset_n = 1'b1;
    p = m_count(8'b0011, 4) * m_count(8'b0001, 4);
    send_frame(8'b0011, 8'b0001, 4, 1'b1, rk);
    run_emit(1'b0, ones, xfers, lpos, lasts, fv, st, rd, to);
    checks++;
    if (ones !== p || lpos !== p || !fv) begin
      errors++;
      $display("FAIL rstmid_next: ones=%0d pos=%0d want %0d", ones, lpos, p);
    end
  endtask

  task automatic test_random;
    int ones, xfers, lpos, lasts, n, p, eb;
    bit fv, st, rd, to, rk, last, tog;
    logic [7:0] a, b;
    for (int k = 0; k < 20; k++) begin
      n    = $urandom_range(1, 6);
      a    = 8'($urandom);
      b    = 8'($urandom);
      last = 1'($urandom);
      tog  = 1'($urandom);
      p    = m_count(a, n) * m_count(b, n);
      eb   = m_beats(p, last);
      send_frame(a, b, n, last, rk);
      run_emit(tog, ones, xfers, lpos, lasts, fv, st, rd, to);
      checks++;
      if (xfers !== eb || ones !== p || lasts !== (last ? 1 : 0) || (last && lpos !== eb)
          || to || !st || !rd) begin
        errors++;
        $display("FAIL rand_frame%0d: xfers=%0d ones=%0d lasts=%0d pos=%0d want %0d/%0d/%0d/%0d",
                 k, xfers, ones, lasts, lpos, eb, p, last, eb);
      end
      checks++;
      if (bus.overflow !== ovf_m) begin
        errors++;
        $display("FAIL rand_ovf%0d: got %b want %b", k, bus.overflow, ovf_m);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset;
    test_single;
    test_accum;
    test_zero;
    test_backpressure;
    test_overflow;
    test_reset_mid_emit;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
